// File: rtl/vpu_ialu_seq.sv
// vpu_ialu_seq: element-serial sequencer for one shared 16-bit integer ALU lane.
// Feeds one element pair per cycle and returns packed results plus a flag mask.
module vpu_ialu_seq #(
  parameter int VLEN = 8,
  parameter int IW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [IW:0]          req_vl,
  input  logic                 req_scalar,
  input  logic [15:0]          req_sdata,
  input  logic [VLEN*16-1:0]   req_src1,
  input  logic [VLEN*16-1:0]   req_src2,
  output logic [15:0]          alu_ds1,
  output logic [15:0]          alu_ds2,
  output logic [15:0]          alu_rs,
  output logic                 alu_vec_en,
  output logic                 alu_enable,
  output logic [10:0]          alu_sel,
  input  logic [15:0]          alu_rd,
  input  logic                 alu_gt,
  input  logic                 alu_eq,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [VLEN*16-1:0]   resp_data,
  output logic [VLEN-1:0]      resp_mask,
  output logic                 resp_err
);

  localparam int AW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [IW:0] VMAX = (IW+1)'(VLEN);
  localparam logic [IW:0] ONE  = (IW+1)'(1);
  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_CMP  = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [3:0]             op_q;
  logic                   scalar_q;
  logic [15:0]            sdata_q;
  logic [VLEN-1:0][15:0]  src1_q;
  logic [VLEN-1:0][15:0]  src2_q;
  logic [VLEN-1:0][15:0]  res_q;
  logic [VLEN-1:0]        mask_q;
  logic [IW:0]            vl_q;
  logic [IW-1:0]          idx_q;
  logic                   err_q;

  logic           accept;
  logic           illegal;
  logic           last;
  logic           run;
  logic           done;
  logic [IW:0]    vl_eff;
  logic [AW-1:0]  ei;

  assign illegal = req_op > OP_CMP;
  assign vl_eff  = (req_vl > VMAX) ? VMAX : req_vl;
  assign accept  = req_valid && (state == IDLE) && !flush;
  assign ei      = idx_q[AW-1:0];
  assign last    = {1'b0, idx_q} == (vl_q - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // flush outranks both accept and the response handshake
  always_comb begin
    state_nx = state;
    priority case (1'b1)
      flush: state_nx = IDLE;
      state == IDLE: begin
        if (req_valid)
          state_nx = (illegal || vl_eff == '0) ? DONE : RUN;
      end
      state == RUN:  if (last) state_nx = DONE;
      state == DONE: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      scalar_q <= 1'b0;
      sdata_q  <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      res_q    <= '0;
      mask_q   <= '0;
      vl_q     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else if (flush) begin
      op_q     <= '0;
      scalar_q <= 1'b0;
      sdata_q  <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      res_q    <= '0;
      mask_q   <= '0;
      vl_q     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q     <= req_op;
      scalar_q <= req_scalar;
      sdata_q  <= req_sdata;
      src1_q   <= req_src1;
      src2_q   <= req_src2;
      res_q    <= '0;
      mask_q   <= '0;
      vl_q     <= vl_eff;
      idx_q    <= '0;
      err_q    <= illegal;
    end else if (state == RUN) begin
      res_q[ei]  <= (op_q == OP_CMP) ? 16'h0 : alu_rd;
      mask_q[ei] <= (op_q == OP_CMP) ? alu_gt : alu_eq;
      idx_q      <= idx_q + IW'(1);
    end
  end

  // outputs are forced low while reset is held
  assign run  = rst_n && (state == RUN);
  assign done = rst_n && (state == DONE);

  always_comb begin
    alu_ds1    = '0;
    alu_ds2    = '0;
    alu_rs     = '0;
    alu_vec_en = 1'b0;
    alu_enable = rst_n;
    alu_sel    = '0;
    if (run) begin
      alu_ds1    = src1_q[ei];
      alu_vec_en = !scalar_q;
      alu_ds2    = scalar_q ? sdata_q : 16'h0;
      alu_rs     = scalar_q ? 16'h0 : src2_q[ei];
      alu_enable = op_q != OP_PASS;
      unique case (op_q)
        4'd1:    alu_sel = 11'b000_0000_0010;
        4'd2:    alu_sel = 11'b000_0000_0100;
        4'd3:    alu_sel = 11'b000_0000_1000;
        4'd4:    alu_sel = 11'b000_0001_0000;
        4'd5:    alu_sel = 11'b000_0010_0000;
        4'd6:    alu_sel = 11'b000_0100_0000;
        4'd7:    alu_sel = 11'b000_1000_0000;
        4'd8:    alu_sel = 11'b001_0000_0000;
        4'd9:    alu_sel = 11'b010_0000_0000;
        4'd10:   alu_sel = 11'b100_0000_0000;
        default: alu_sel = '0;
      endcase
    end
  end

  assign req_ready  = rst_n && (state == IDLE);
  assign resp_valid = done;
  assign resp_data  = done ? res_q : '0;
  assign resp_mask  = done ? mask_q : '0;
  assign resp_err   = done && err_q;

endmodule
